// File: rtl/infix_to_postfix_if.sv
// Token interface for the infix-to-postfix converter.
// Infix tokens go in (in_valid/op_mode/in). The postfix burst and busy come out.
// When INFIX_ERR_CHECK_EN is defined, the interface also carries the err flag.
interface infix_to_postfix_if;
    logic       in_valid;
    logic       op_mode;
    logic [3:0] in;
    logic       busy;
    logic       out_valid;
    logic       out_mode;
    logic [3:0] out;
`ifdef INFIX_ERR_CHECK_EN
    logic       err;
`endif

    modport master (
        output in_valid, op_mode, in,
        input  busy, out_valid, out_mode, out
`ifdef INFIX_ERR_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  in_valid, op_mode, in,
        output busy, out_valid, out_mode, out
`ifdef INFIX_ERR_CHECK_EN
        , output err
`endif
    );
endinterface

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter from a serial infix token burst to a buffered postfix burst.
// The operator stack is two entries deep: one add/sub at the bottom and one mul above it.
// This depth is enough because mul is the only operator that binds tighter.
// Optional feature: INFIX_ERR_CHECK_EN adds the err flag and suppresses the burst
// for a malformed expression.
module infix_to_postfix #(
    parameter int MAX_TOKENS = 31,
    parameter int CNT_W      = 5
) (
    input logic               clk,
    input logic               rst,
    infix_to_postfix_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_SEND   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;

    localparam logic [CNT_W:0]   MAX_W = MAX_TOKENS[CNT_W:0];
    localparam logic [CNT_W-1:0] MAX_C = MAX_TOKENS[CNT_W-1:0];

    logic [1:0]       state;
    logic [CNT_W-1:0] count, count_nxt, idx, idx1;
    logic [CNT_W:0]   sum;
    logic [3:0]       stk0, stk1, stk0_nxt, stk1_nxt, top;
    logic [1:0]       stk_cnt, stk_cnt_nxt;
    logic [4:0]       w0, w1;
    logic [1:0]       wr_n;
    logic             tok_en, op_known;
    logic [4:0]       buf_mem [MAX_TOKENS];

    assign bus.busy = (state != S_IDLE);
    assign idx1     = count + 1'b1;

    // Per-cycle token processing: up to two buffer writes and the next stack contents.
    always_comb begin
        w0          = '0;
        w1          = '0;
        wr_n        = 2'd0;
        stk0_nxt    = stk0;
        stk1_nxt    = stk1;
        stk_cnt_nxt = stk_cnt;
        top         = (stk_cnt == 2'd2) ? stk1 : stk0;
        tok_en      = ((state == S_IDLE) || (state == S_ACCEPT)) && bus.in_valid;
        op_known    = (bus.in == OP_ADD) || (bus.in == OP_SUB) || (bus.in == OP_MUL);
        if (tok_en && !bus.op_mode) begin
            w0   = {1'b0, bus.in};
            wr_n = 2'd1;
        end else if (tok_en && bus.in == OP_MUL) begin
            if (stk_cnt != 2'd0 && top == OP_MUL) begin
                w0   = {1'b1, OP_MUL};
                wr_n = 2'd1;
            end else if (stk_cnt == 2'd0) begin
                stk0_nxt    = OP_MUL;
                stk_cnt_nxt = 2'd1;
            end else begin
                stk1_nxt    = OP_MUL;
                stk_cnt_nxt = 2'd2;
            end
        end else if ((tok_en && op_known) || state == S_DRAIN) begin
            if (stk_cnt == 2'd2) begin
                w0   = {1'b1, stk1};
                w1   = {1'b1, stk0};
                wr_n = 2'd2;
            end else if (stk_cnt == 2'd1) begin
                w0   = {1'b1, stk0};
                wr_n = 2'd1;
            end
            if (state == S_DRAIN) begin
                stk_cnt_nxt = 2'd0;
            end else begin
                stk0_nxt    = bus.in;
                stk_cnt_nxt = 2'd1;
            end
        end
        sum       = {1'b0, count} + {{(CNT_W-1){1'b0}}, wr_n};
        count_nxt = (sum > MAX_W) ? MAX_C : sum[CNT_W-1:0];
    end

`ifdef INFIX_ERR_CHECK_EN
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_OPND = 2'd1;
    localparam logic [1:0] K_OPR  = 2'd2;

    logic [1:0] prev, prev_eff;
    logic       err_set, drain_bad;

    // Error detection for the token being accepted and at the end of the expression.
    always_comb begin
        prev_eff  = (state == S_IDLE) ? K_NONE : prev;
        err_set   = tok_en && ((!bus.op_mode && prev_eff == K_OPND) ||
                               (bus.op_mode && !op_known) ||
                               (bus.op_mode && op_known && prev_eff != K_OPND) ||
                               (sum > MAX_W));
        drain_bad = bus.err || (prev == K_OPR);
    end

    // Error flag: cleared by the first token of an expression, otherwise sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err <= 1'b0;
            prev    <= K_NONE;
        end else if (tok_en) begin
            bus.err <= ((state == S_ACCEPT) && bus.err) || err_set;
            if (!bus.op_mode)
                prev <= K_OPND;
            else if (op_known)
                prev <= K_OPR;
            else
                prev <= prev_eff;
        end else if (state == S_DRAIN && prev == K_OPR) begin
            bus.err <= 1'b1;
        end
    end
`else
    logic drain_bad;
    assign drain_bad = 1'b0;
`endif

    // Postfix buffer writes. Entries past MAX_TOKENS are dropped.
    always_ff @(posedge clk) begin
        if (wr_n != 2'd0 && count < MAX_C)
            buf_mem[count] <= w0;
        if (wr_n == 2'd2 && count < MAX_C - 1'b1)
            buf_mem[idx1] <= w1;
    end

    // Control FSM: accept tokens, drain the stack, then replay the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            count         <= '0;
            idx           <= '0;
            stk0          <= '0;
            stk1          <= '0;
            stk_cnt       <= 2'd0;
            bus.out_valid <= 1'b0;
            bus.out_mode  <= 1'b0;
            bus.out       <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_ACCEPT: begin
                    if (bus.in_valid) begin
                        state   <= S_ACCEPT;
                        count   <= count_nxt;
                        stk0    <= stk0_nxt;
                        stk1    <= stk1_nxt;
                        stk_cnt <= stk_cnt_nxt;
                    end else if (state == S_ACCEPT) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    stk_cnt <= stk_cnt_nxt;
                    idx     <= '0;
                    if (drain_bad) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else begin
                        state <= S_SEND;
                        count <= count_nxt;
                    end
                end
                default: begin
                    if (idx < count) begin
                        bus.out_valid               <= 1'b1;
                        {bus.out_mode, bus.out}     <= buf_mem[idx];
                        idx                         <= idx + 1'b1;
                    end else begin
                        bus.out_valid <= 1'b0;
                        state         <= S_IDLE;
                        count         <= '0;
                        idx           <= '0;
                    end
                end
            endcase
        end
    end
endmodule
